coherence_bus_arbiter: RTL and testbench

Parametrised request arbiter placed in front of the coherence bus controller FSM: it collects bus requests from all L1 ports (CPUS = NUM_HARTS*2), selects one per transaction, and holds that grant until the controller signals completion. It generalises the controller's fixed GRANT_R/RX/EVICT/INV choice with:

- any number of requesters;
- selectable round-robin or fixed-priority mode;
- an eviction-first priority class;
- per-requester starvation counters that force service.

---
 rtl/coherence_arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 34 +++
 rtl/coherence_bus_arbiter.sv | 136 +++++++++++++
 tb/tb_coherence_bus_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coherence_arb_pkg.sv
// Shared types for the coherence bus arbiter: request classes, FSM states
// and the grant-index width helper.
package coherence_arb_pkg;

  typedef enum logic [1:0] {
    REQ_R     = 2'd0,
    REQ_RX    = 2'd1,
    REQ_EVICT = 2'd2,
    REQ_INV   = 2'd3
  } arb_req_t;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  function automatic int idw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating first-one finder: returns the first set candidate at or after
// start_i, wrapping modulo NREQ. start_i = 0 gives plain lowest-index.
module rr_pick
  import coherence_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = idw_of(NREQ)
) (
  input  logic [NREQ-1:0] cand_i,
  input  logic [IDW-1:0]  start_i,
  output logic            found_o,
  output logic [IDW-1:0]  idx_o
);

  localparam logic [IDW:0] NREQ_W = (IDW + 1)'(NREQ);

  logic [NREQ-1:0] rot;
  logic [IDW-1:0]  off;
  logic [IDW:0]    sum;

  always_comb begin
    // Rotate so that bit 0 is the start position, then search upward.
    rot = NREQ'({cand_i, cand_i} >> start_i);
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDW'(i);
    end
    sum = {1'b0, start_i} + {1'b0, off};
    if (sum >= NREQ_W) sum = sum - NREQ_W;
    found_o = |cand_i;
    idx_o   = sum[IDW-1:0];
  end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// Request arbiter in front of the coherence bus controller: starvation
// override, eviction-first class, then round-robin or fixed priority.
//
// state       | meaning
// ARB_IDLE    | waiting for an unmasked request; picks and registers a winner
// ARB_GRANT   | grant held constant until done
// ARB_RELEASE | outputs cleared, previous winner masked for one cycle
module coherence_bus_arbiter
  import coherence_arb_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int MODE         = 0,
  parameter int EVICT_PRIO   = 1,
  parameter int STARVE_LIMIT = 8,
  localparam int IDW         = idw_of(NREQ)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_type,
  input  logic              done,
  output logic              grant_valid,
  output logic [IDW-1:0]    grant_id,
  output logic [NREQ-1:0]   grant_onehot,
  output arb_req_t          grant_type,
  output logic              forced
);

  localparam int             CW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]  LIMIT   = CW'(STARVE_LIMIT);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);
  localparam logic [IDW-1:0] ID_ZERO = '0;

  arb_state_t     state_q;
  logic [IDW-1:0] last_id_q;
  logic [CW-1:0]  cnt_q [NREQ];

  arb_req_t        type_v [NREQ];
  logic [NREQ-1:0] mask, req_m, starved, evict, cand, win_oh;
  logic [IDW-1:0]  rr_start, cand_start, starve_id, cand_id, win_id;
  logic            starve_found, cand_found;
  arb_req_t        win_type;

  always_comb begin
    mask    = '0;
    starved = '0;
    evict   = '0;
    for (int i = 0; i < NREQ; i++) begin
      type_v[i] = arb_req_t'(req_type[2*i +: 2]);
      mask[i]   = (state_q == ARB_RELEASE) && (last_id_q == IDW'(i));
    end
    req_m = req & ~mask;
    for (int i = 0; i < NREQ; i++) begin
      starved[i] = req_m[i] && (cnt_q[i] == LIMIT);
      evict[i]   = req_m[i] && (type_v[i] == REQ_EVICT);
    end
    cand       = ((EVICT_PRIO != 0) && (|evict)) ? evict : req_m;
    rr_start   = (last_id_q == LAST_ID) ? ID_ZERO : last_id_q + IDW'(1);
    cand_start = (MODE != 0) ? ID_ZERO : rr_start;
  end

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick_starve (
    .cand_i  (starved),
    .start_i (ID_ZERO),
    .found_o (starve_found),
    .idx_o   (starve_id)
  );

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick_cand (
    .cand_i  (cand),
    .start_i (cand_start),
    .found_o (cand_found),
    .idx_o   (cand_id)
  );

  always_comb begin
    win_id   = starve_found ? starve_id : cand_id;
    win_type = REQ_R;
    win_oh   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == IDW'(i)) begin
        win_type  = type_v[i];
        win_oh[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= ARB_IDLE;
      last_id_q    <= LAST_ID;
      grant_valid  <= 1'b0;
      grant_id     <= '0;
      grant_onehot <= '0;
      grant_type   <= REQ_R;
      forced       <= 1'b0;
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      // Counters age only on grants issued to someone else.
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i]) begin
          cnt_q[i] <= '0;
        end else if ((state_q == ARB_IDLE) && cand_found) begin
          if (win_id == IDW'(i))  cnt_q[i] <= '0;
          else if (cnt_q[i] != LIMIT) cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
      case (state_q)
        ARB_IDLE: begin
          if (cand_found) begin
            state_q      <= ARB_GRANT;
            grant_valid  <= 1'b1;
            grant_id     <= win_id;
            grant_onehot <= win_oh;
            grant_type   <= win_type;
            forced       <= starve_found;
            last_id_q    <= win_id;
          end
        end
        ARB_GRANT: begin
          if (done) begin
            state_q      <= ARB_RELEASE;
            grant_valid  <= 1'b0;
            grant_id     <= '0;
            grant_onehot <= '0;
            grant_type   <= REQ_R;
            forced       <= 1'b0;
          end
        end
        ARB_RELEASE: state_q <= ARB_IDLE;
        default:     state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Bench for coherence_bus_arbiter: round-robin, fixed-priority and
// single-port instances driven from shared stimulus.
module tb_coherence_bus_arbiter;
  import coherence_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = '0;
  logic [7:0] req_type = '0;
  logic       done = 1'b0;

  logic a_valid, a_forced, b_valid, b_forced, c_valid, c_forced;
  logic [1:0] a_id, b_id;
  logic [3:0] a_oh, b_oh;
  logic [0:0] c_id, c_oh;
  arb_req_t   a_type, b_type, c_type;

  int errors = 0;
  int checks = 0;

  int m_last [2];
  int m_cnt  [2][4];
  int m_lim  [2] = '{8, 2};
  int m_mode [2] = '{0, 1};

  always #5 clk = ~clk;

  coherence_bus_arbiter #(.NREQ(4), .MODE(0), .EVICT_PRIO(1), .STARVE_LIMIT(8)) u_rr (
    .CLK(clk), .nRST(rst_n), .req(req), .req_type(req_type), .done(done),
    .grant_valid(a_valid), .grant_id(a_id), .grant_onehot(a_oh), .grant_type(a_type), .forced(a_forced));

  coherence_bus_arbiter #(.NREQ(4), .MODE(1), .EVICT_PRIO(1), .STARVE_LIMIT(2)) u_fx (
    .CLK(clk), .nRST(rst_n), .req(req), .req_type(req_type), .done(done),
    .grant_valid(b_valid), .grant_id(b_id), .grant_onehot(b_oh), .grant_type(b_type), .forced(b_forced));

  coherence_bus_arbiter #(.NREQ(1), .MODE(0), .EVICT_PRIO(1), .STARVE_LIMIT(8)) u_one (
    .CLK(clk), .nRST(rst_n), .req(req[0:0]), .req_type(req_type[1:0]), .done(done),
    .grant_valid(c_valid), .grant_id(c_id), .grant_onehot(c_oh), .grant_type(c_type), .forced(c_forced));

  task automatic apply_reset();
    rst_n = 1'b0; req = '0; req_type = '0; done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(posedge clk); #1;
      if (a_valid) ok = 1'b1;
    end
  endtask

  task automatic finish_txn();
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
  endtask

  // Reference: spec precedence rules evaluated over plain integer state.
  function automatic void model_pick(input int m, input logic [3:0] r, input logic [7:0] ty,
                                     output int w, output bit f);
    logic [3:0] cand, ev;
    int idx;
    w = -1; f = 1'b0; ev = '0;
    for (int i = 0; i < 4; i++)
      if (w < 0 && r[i] && m_cnt[m][i] == m_lim[m]) begin w = i; f = 1'b1; end
    if (w < 0) begin
      for (int i = 0; i < 4; i++) if (r[i] && ty[2*i +: 2] == 2'd2) ev[i] = 1'b1;
      cand = (ev != 0) ? ev : r;
      if (m_mode[m] == 1) begin
        for (int i = 0; i < 4; i++) if (w < 0 && cand[i]) w = i;
      end else begin
        for (int k = 1; k <= 4; k++) begin
          idx = (m_last[m] + k) % 4;
          if (w < 0 && cand[idx]) w = idx;
        end
      end
    end
  endfunction

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", a_valid); end
    checks++; if (a_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", a_id); end
    checks++; if (a_oh !== 4'b0) begin errors++; $display("FAIL reset_onehot: got %b want 0000", a_oh); end
    checks++; if (a_type !== REQ_R) begin errors++; $display("FAIL reset_type: got %0d want 0", a_type); end
    checks++; if (a_forced !== 1'b0) begin errors++; $display("FAIL reset_forced: got %0b want 0", a_forced); end
    checks++; if ({b_valid, c_valid} !== 2'b00) begin errors++; $display("FAIL reset_valid_bc: got %b want 00", {b_valid, c_valid}); end
    apply_reset();
  endtask

  task automatic test_rr_rotation();
    int exp_ids[5] = '{0, 1, 2, 3, 0};
    int hi;
    bit ok;
    apply_reset();
    req = 4'b1111; req_type = '0;
    for (int g = 0; g < 5; g++) begin
      wait_grant(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rr_timeout: no grant %0d", g); end
      checks++; if (a_id !== 2'(exp_ids[g])) begin errors++; $display("FAIL rr_id[%0d]: got %0d want %0d", g, a_id, exp_ids[g]); end
      hi = 1;
      @(posedge clk); #1;
      if (a_valid) hi++;
      finish_txn();
      if (a_valid) hi++;
      checks++; if (hi != 2) begin errors++; $display("FAIL rr_pulse[%0d]: got %0d cycles want 2", g, hi); end
    end
    req = '0;
  endtask

  task automatic test_evict();
    int exp_ids[3] = '{3, 0, 1};
    bit ok;
    apply_reset();
    req = 4'b1011; req_type = 8'b10_00_00_00;
    for (int g = 0; g < 3; g++) begin
      wait_grant(ok);
      checks++; if (!ok) begin errors++; $display("FAIL evict_timeout: no grant %0d", g); end
      checks++; if (a_id !== 2'(exp_ids[g])) begin errors++; $display("FAIL evict_id[%0d]: got %0d want %0d", g, a_id, exp_ids[g]); end
      if (g == 0) begin
        checks++; if (a_type !== REQ_EVICT) begin errors++; $display("FAIL evict_type: got %0d want 2", a_type); end
      end
      finish_txn();
      if (g == 0) begin req = 4'b0011; req_type = '0; end
    end
    req = '0;
  endtask

  task automatic test_starvation();
    int  exp_ids[3] = '{0, 0, 2};
    bit  exp_f[3]   = '{1'b0, 1'b0, 1'b1};
    bit ok;
    apply_reset();
    req = 4'b0101; req_type = '0;
    for (int g = 0; g < 3; g++) begin
      wait_grant(ok);
      checks++; if (!ok || !b_valid) begin errors++; $display("FAIL starve_timeout: no grant %0d", g); end
      checks++; if (b_id !== 2'(exp_ids[g])) begin errors++; $display("FAIL starve_id[%0d]: got %0d want %0d", g, b_id, exp_ids[g]); end
      checks++; if (b_forced !== exp_f[g]) begin errors++; $display("FAIL starve_forced[%0d]: got %0b want %0b", g, b_forced, exp_f[g]); end
      finish_txn();
    end
    req = '0;
  endtask

  task automatic test_fixed();
    bit ok;
    apply_reset();
    req = 4'b1100; req_type = '0;
    for (int g = 0; g < 2; g++) begin
      wait_grant(ok);
      checks++; if (!ok || !b_valid) begin errors++; $display("FAIL fixed_timeout: no grant %0d", g); end
      checks++; if (b_id !== 2'd2) begin errors++; $display("FAIL fixed_id[%0d]: got %0d want 2", g, b_id); end
      checks++; if (b_oh !== 4'b0100) begin errors++; $display("FAIL fixed_onehot[%0d]: got %b want 0100", g, b_oh); end
      finish_txn();
    end
    req = '0;
  endtask

  task automatic test_hold_ignore();
    bit ok;
    apply_reset();
    finish_txn();
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL idle_done: got valid %0b want 0", a_valid); end
    req = 4'b0010; req_type = 8'b00_00_01_00;
    wait_grant(ok);
    checks++; if (!ok || a_id !== 2'd1 || a_type !== REQ_RX) begin errors++; $display("FAIL hold_grant: got id %0d type %0d want 1/1", a_id, a_type); end
    req = '0; req_type = 8'hFF;
    for (int h = 0; h < 3; h++) begin
      @(posedge clk); #1;
      checks++; if (a_valid !== 1'b1 || a_id !== 2'd1 || a_type !== REQ_RX) begin errors++; $display("FAIL hold[%0d]: got v%0b id %0d type %0d want v1 id 1 type 1", h, a_valid, a_id, a_type); end
    end
    finish_txn();
    checks++; if (a_valid !== 1'b0 || a_oh !== 4'b0) begin errors++; $display("FAIL hold_release: got v%0b oh %b want v0 oh 0000", a_valid, a_oh); end
    finish_txn();
    finish_txn();
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL spurious_done: got valid %0b want 0", a_valid); end
    req = 4'b0001; req_type = '0;
    @(posedge clk); #1;
    checks++; if (a_valid !== 1'b1 || a_id !== 2'd0) begin errors++; $display("FAIL after_spurious: got v%0b id %0d want v1 id 0", a_valid, a_id); end
    finish_txn();
    req = '0;
  endtask

  task automatic test_reset_mid_grant();
    bit ok;
    apply_reset();
    req = 4'b0100;
    wait_grant(ok);
    checks++; if (!ok || a_id !== 2'd2) begin errors++; $display("FAIL midrst_pre: got id %0d want 2", a_id); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({a_valid, a_id, a_oh, a_forced} !== 8'b0 || a_type !== REQ_R) begin errors++; $display("FAIL midrst_outputs: got v%0b id %0d oh %b f%0b type %0d want all 0", a_valid, a_id, a_oh, a_forced, a_type); end
    checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL midrst_fx_valid: got %0b want 0", b_valid); end
    req = 4'b0001;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (a_valid !== 1'b1 || a_id !== 2'd0) begin errors++; $display("FAIL midrst_regrant: got v%0b id %0d want v1 id 0", a_valid, a_id); end
    finish_txn();
    req = '0;
  endtask

  task automatic test_single();
    apply_reset();
    req = 4'b0001; req_type = 8'b00_00_00_11;
    @(posedge clk); #1;
    checks++; if (c_valid !== 1'b1 || c_id !== 1'b0 || c_oh !== 1'b1 || c_type !== REQ_INV) begin errors++; $display("FAIL single_grant: got v%0b id %0d oh %b type %0d want v1 id 0 oh 1 type 3", c_valid, c_id, c_oh, c_type); end
    finish_txn();
    checks++; if (c_valid !== 1'b0) begin errors++; $display("FAIL single_release: got %0b want 0", c_valid); end
    @(posedge clk); #1;
    checks++; if (c_valid !== 1'b0) begin errors++; $display("FAIL single_idle_gap: got %0b want 0", c_valid); end
    @(posedge clk); #1;
    checks++; if (c_valid !== 1'b1) begin errors++; $display("FAIL single_regrant: got %0b want 1", c_valid); end
    finish_txn();
    req = '0;
  endtask

  task automatic test_random();
    logic [3:0] prev, r;
    logic [7:0] ty;
    int w[2];
    bit f[2];
    arb_req_t et[2];
    int hold;
    apply_reset();
    prev = '0;
    for (int m = 0; m < 2; m++) begin
      m_last[m] = 3;
      for (int i = 0; i < 4; i++) m_cnt[m][i] = 0;
    end
    for (int t = 0; t < 40; t++) begin
      r = 4'($urandom_range(1, 15));
      ty = 8'($urandom);
      req = r; req_type = ty;
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < 4; i++) if (!prev[i]) m_cnt[m][i] = 0;
        model_pick(m, r, ty, w[m], f[m]);
        et[m] = arb_req_t'(ty[2*w[m] +: 2]);
        for (int i = 0; i < 4; i++) begin
          if (!r[i] || i == w[m]) m_cnt[m][i] = 0;
          else if (m_cnt[m][i] < m_lim[m]) m_cnt[m][i]++;
        end
        m_last[m] = w[m];
      end
      if (t > 0) begin
        @(posedge clk); #1;
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL rnd_gap[%0d]: got valid %0b want 0", t, a_valid); end
      end
      @(posedge clk); #1;
      checks++; if (a_valid !== 1'b1 || a_id !== 2'(w[0]) || a_oh !== 4'(1 << w[0]) || a_type !== et[0] || a_forced !== f[0]) begin
        errors++; $display("FAIL rnd_rr[%0d]: got v%0b id %0d oh %b type %0d f%0b want v1 id %0d type %0d f%0b", t, a_valid, a_id, a_oh, a_type, a_forced, w[0], et[0], f[0]); end
      checks++; if (b_valid !== 1'b1 || b_id !== 2'(w[1]) || b_oh !== 4'(1 << w[1]) || b_type !== et[1] || b_forced !== f[1]) begin
        errors++; $display("FAIL rnd_fx[%0d]: got v%0b id %0d oh %b type %0d f%0b want v1 id %0d type %0d f%0b", t, b_valid, b_id, b_oh, b_type, b_forced, w[1], et[1], f[1]); end
      hold = $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) begin
        if ($urandom_range(0, 1) == 1) begin req[w[0]] = 1'b0; req_type = 8'($urandom); end
        @(posedge clk); #1;
        checks++; if (a_id !== 2'(w[0]) || b_id !== 2'(w[1]) || a_type !== et[0] || b_type !== et[1] || !a_valid || !b_valid) begin
          errors++; $display("FAIL rnd_hold[%0d]: got ids %0d/%0d want %0d/%0d", t, a_id, b_id, w[0], w[1]); end
      end
      prev = req;
      finish_txn();
      checks++; if (a_valid !== 1'b0 || b_valid !== 1'b0 || b_oh !== 4'b0) begin errors++; $display("FAIL rnd_release[%0d]: got v%0b/%0b want 0/0", t, a_valid, b_valid); end
    end
    req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rr_rotation();
    test_evict();
    test_starvation();
    test_fixed();
    test_hold_ignore();
    test_reset_mid_grant();
    test_single();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
